// File: rtl/mtmp_pow_calc.sv
// Pipelined over-exposure weight: mtmp = (max(imoy_i_j-imoy_ii_jj,0)/divisor)^P, Q1.DW_DEC result.
// Optional clock-enable port `en` when MTMP_CE_EN is defined.
module mtmp_pow_calc #(
  parameter int unsigned DW_IN  = 10,
  parameter int unsigned DW_DEC = 8,
  parameter int unsigned DW_DIV = 10
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MTMP_CE_EN
  input  logic              en,
`endif
  input  logic              in_vld,
  input  logic [DW_IN-1:0]  imoy_i_j,
  input  logic [DW_IN-1:0]  imoy_ii_jj,
  input  logic [DW_DIV-1:0] divisor,
  input  logic [1:0]        pow_sel,
  output logic              out_vld,
  output logic [DW_DEC:0]   mtmp,
  output logic              div0
);

  localparam int unsigned NW     = DW_IN + DW_DEC;
  localparam int unsigned DW_OUT = DW_DEC + 1;
  localparam logic [2*DW_OUT-1:0] RND     = (2*DW_OUT)'(1) << (DW_DEC - 1);
  localparam logic [2*DW_OUT-1:0] SAT_LIM = (2*DW_OUT)'(1) << DW_OUT;

  logic adv;
`ifdef MTMP_CE_EN
  assign adv = en;
`else
  assign adv = 1'b1;
`endif

  // Round-half-up square with saturation to all-ones.
  function automatic logic [DW_OUT-1:0] sq_step(input logic [DW_OUT-1:0] x);
    logic [2*DW_OUT-1:0] p;
    logic [2*DW_OUT-1:0] r;
    p = {{DW_OUT{1'b0}}, x} * {{DW_OUT{1'b0}}, x};
    r = (p + RND) >> DW_DEC;
    return (r >= SAT_LIM) ? {DW_OUT{1'b1}} : r[DW_OUT-1:0];
  endfunction

  logic [DW_IN-1:0] diff;
  assign diff = (imoy_i_j > imoy_ii_jj) ? imoy_i_j - imoy_ii_jj : '0;

  // Index 0 is S0; index k holds the sample after quotient bit k. nq shifts numerator out of the
  // top while quotient bits enter at the bottom, so nq_q[NW] is the full quotient.
  logic              vld_q [NW+1];
  logic [NW-1:0]     nq_q  [NW+1];
  logic [DW_DIV-1:0] rem_q [NW+1];
  logic [DW_DIV-1:0] dv_q  [NW+1];
  logic [1:0]        ps_q  [NW+1];
  logic              z_q   [NW+1];

  logic [DW_DIV:0] sh  [1:NW];
  logic [DW_DIV:0] sub [1:NW];
  logic            ge  [1:NW];

  always_comb begin
    for (int k = 1; k <= int'(NW); k++) begin
      sh[k]  = {rem_q[k-1], nq_q[k-1][NW-1]};
      ge[k]  = sh[k] >= {1'b0, dv_q[k-1]};
      sub[k] = sh[k] - {1'b0, dv_q[k-1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= int'(NW); k++) begin
        vld_q[k] <= 1'b0;
        nq_q[k]  <= '0;
        rem_q[k] <= '0;
        dv_q[k]  <= '0;
        ps_q[k]  <= '0;
        z_q[k]   <= 1'b0;
      end
    end else if (adv) begin
      vld_q[0] <= in_vld;
      if (in_vld) begin
        nq_q[0]  <= {diff, {DW_DEC{1'b0}}};
        rem_q[0] <= '0;
        dv_q[0]  <= divisor;
        ps_q[0]  <= pow_sel;
        z_q[0]   <= (divisor == '0);
      end
      for (int k = 1; k <= int'(NW); k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          rem_q[k] <= ge[k] ? sub[k][DW_DIV-1:0] : sh[k][DW_DIV-1:0];
          nq_q[k]  <= {nq_q[k-1][NW-2:0], ge[k]};
          dv_q[k]  <= dv_q[k-1];
          ps_q[k]  <= ps_q[k-1];
          z_q[k]   <= z_q[k-1];
        end
      end
    end
  end

  // Saturate the quotient into Q1.DW_DEC; a zero divisor forces all ones.
  logic [DW_OUT-1:0] x_clamp;
  always_comb begin
    if (z_q[NW] || (|nq_q[NW][NW-1:DW_OUT])) x_clamp = {DW_OUT{1'b1}};
    else                                    x_clamp = nq_q[NW][DW_OUT-1:0];
  end

  logic [DW_OUT-1:0] sq_x_q   [3];
  logic [1:0]        sq_ps_q  [3];
  logic              sq_z_q   [3];
  logic              sq_vld_q [3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        sq_x_q[i]   <= '0;
        sq_ps_q[i]  <= '0;
        sq_z_q[i]   <= 1'b0;
        sq_vld_q[i] <= 1'b0;
      end
    end else if (adv) begin
      sq_vld_q[0] <= vld_q[NW];
      if (vld_q[NW]) begin
        sq_x_q[0]  <= (ps_q[NW] != 2'd0) ? sq_step(x_clamp) : x_clamp;
        sq_ps_q[0] <= ps_q[NW];
        sq_z_q[0]  <= z_q[NW];
      end
      sq_vld_q[1] <= sq_vld_q[0];
      if (sq_vld_q[0]) begin
        sq_x_q[1]  <= (sq_ps_q[0] >= 2'd2) ? sq_step(sq_x_q[0]) : sq_x_q[0];
        sq_ps_q[1] <= sq_ps_q[0];
        sq_z_q[1]  <= sq_z_q[0];
      end
      sq_vld_q[2] <= sq_vld_q[1];
      if (sq_vld_q[1]) begin
        sq_x_q[2]  <= (sq_ps_q[1] == 2'd3) ? sq_step(sq_x_q[1]) : sq_x_q[1];
        sq_ps_q[2] <= sq_ps_q[1];
        sq_z_q[2]  <= sq_z_q[1];
      end
    end
  end

  assign out_vld = sq_vld_q[2];
  assign mtmp    = sq_x_q[2];
  assign div0    = sq_z_q[2];

endmodule

// File: tb/tb_mtmp_pow_calc.sv
// Self-checking bench for mtmp_pow_calc: directed cases plus randomized traffic against a
// plain-arithmetic reference model and a due-cycle scoreboard.
module tb_mtmp_pow_calc;

  localparam int LAT = 10 + 8 + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_cur = 1'b1;
  logic       in_vld = 1'b0;
  logic [9:0] imoy_i_j = '0;
  logic [9:0] imoy_ii_jj = '0;
  logic [9:0] divisor = '0;
  logic [1:0] pow_sel = '0;
  logic       out_vld;
  logic [8:0] mtmp;
  logic       div0;

  always #5 clk = ~clk;

  mtmp_pow_calc dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef MTMP_CE_EN
    .en         (en_cur),
`endif
    .in_vld     (in_vld),
    .imoy_i_j   (imoy_i_j),
    .imoy_ii_jj (imoy_ii_jj),
    .divisor    (divisor),
    .pow_sel    (pow_sel),
    .out_vld    (out_vld),
    .mtmp       (mtmp),
    .div0       (div0)
  );

  typedef struct {
    int due;
    int m;
    bit z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   exp_vld = 0;
  int   last_m = 0;
  bit   last_z = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  // (max(a-b,0)/div)^P with the specified clamp/round/saturate rules.
  function automatic int ref_mtmp(input int ia, input int ib, input int dv, input int ps);
    int d, x;
    d = (ia > ib) ? ia - ib : 0;
    if (dv == 0) return 511;
    x = (d * 256) / dv;
    if (x > 511) x = 511;
    for (int k = 1; k <= 3; k++) begin
      if (ps >= k) begin
        x = (x * x + 128) / 256;
        if (x > 511) x = 511;
      end
    end
    return x;
  endfunction

  task automatic check_out(input bit en_edge);
    if (en_edge) begin
      if (sb.size() > 0 && sb[0].due == edge_cnt) begin
        exp_vld = 1;
        last_m  = sb[0].m;
        last_z  = sb[0].z;
        void'(sb.pop_front());
      end else begin
        exp_vld = 0;
      end
    end
    check_eq("out_vld", int'(out_vld), int'(exp_vld));
    check_eq("mtmp", int'(mtmp), last_m);
    check_eq("div0", int'(div0), int'(last_z));
  endtask

  task automatic step(input bit v, input int ia, input int ib, input int dv, input int ps,
                      input int exp_m = -1);
    bit en_edge;
    in_vld     = v;
    imoy_i_j   = 10'(ia);
    imoy_ii_jj = 10'(ib);
    divisor    = 10'(dv);
    pow_sel    = 2'(ps);
    en_edge    = en_cur;
    @(posedge clk);
    if (en_edge) begin
      edge_cnt++;
      if (v) sb.push_back('{edge_cnt + LAT - 1, (exp_m >= 0) ? exp_m : ref_mtmp(ia, ib, dv, ps),
                           dv == 0});
    end
    @(negedge clk);
    check_out(en_edge);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
  endtask

  task automatic rand_step();
    int ia, ib, dv, r;
    ia = int'($urandom_range(0, 1023));
    ib = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 200));
    r  = int'($urandom_range(0, 15));
    dv = (r == 0) ? 0 : (r < 4) ? int'($urandom_range(1, 50)) : int'($urandom_range(1, 1023));
    step(1'($urandom_range(0, 1)), ia, ib, dv, int'($urandom_range(0, 3)));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_vld", int'(out_vld), 0);
    check_eq("rst_mtmp", int'(mtmp), 0);
    check_eq("rst_div0", int'(div0), 0);
    rst_n = 1'b1;

    // Unity weight with exact latency
    step(1, 800, 0, 800, 2, 256);
    idle(LAT + 3);
    // All four exponents back to back
    step(1, 400, 0, 800, 0, 128);
    step(1, 400, 0, 800, 1, 64);
    step(1, 400, 0, 800, 2, 16);
    step(1, 400, 0, 800, 3, 1);
    idle(LAT + 3);
    // Clamp and saturation
    step(1, 1023, 0, 800, 1, 418);
    step(1, 1023, 0, 800, 2, 511);
    // Negative/equal difference, zero divisor
    step(1, 100, 300, 800, 3, 0);
    step(1, 100, 300, 5, 0, 0);
    step(1, 500, 500, 37, 1, 0);
    step(1, 5, 0, 0, 0, 511);
    idle(LAT + 3);

    for (int i = 0; i < 300; i++) rand_step();

    // Mid-stream reset discards everything in flight
    rst_n = 1'b0;
    #1;
    check_eq("midrst_out_vld", int'(out_vld), 0);
    check_eq("midrst_mtmp", int'(mtmp), 0);
    check_eq("midrst_div0", int'(div0), 0);
    sb.delete();
    exp_vld = 0;
    last_m  = 0;
    last_z  = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(LAT + 5);

    for (int i = 0; i < 300; i++) rand_step();

`ifdef MTMP_CE_EN
    for (int i = 0; i < 30; i++) rand_step();
    en_cur = 1'b0;
    for (int i = 0; i < 7; i++) rand_step();
    en_cur = 1'b1;
    for (int i = 0; i < 30; i++) rand_step();
`endif

    idle(LAT + 5);
    check_eq("drain_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
